// File: rtl/mem_ctrl_pkg.sv
// Shared types and address helpers for the load/store memory sequencer.
// Addresses are byte addresses; words are 32 bits wide.
package mem_ctrl_pkg;

  typedef enum logic [1:0] {IDLE, REFILL, WRITE, DONE} mac_state_t;

  localparam int WORD_OFF = 2;

  // Base byte address of the cache line holding addr (2**bw_log2 words per line).
  function automatic logic [31:0] line_base(input logic [31:0] addr, input int bw_log2);
    return addr & ~((32'd1 << (bw_log2 + WORD_OFF)) - 32'd1);
  endfunction

  // Word index of addr within its cache line.
  function automatic logic [31:0] word_index(input logic [31:0] addr, input int bw_log2);
    return (addr >> WORD_OFF) & ((32'd1 << bw_log2) - 32'd1);
  endfunction

endpackage

// File: rtl/lat_counter.sv
// Memory latency pacer: counts 0..MEM_LATENCY-1 while enabled and raises tc
// on the last count, then wraps. clr forces the count back to zero.
module lat_counter #(
  parameter  int MEM_LATENCY = 4,
  localparam int LW          = $clog2(MEM_LATENCY + 1)
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          clr,
  input  logic          en,
  output logic [LW-1:0] cnt,
  output logic          tc
);

  localparam logic [LW-1:0] LAST = LW'(MEM_LATENCY - 1);

  assign tc = (cnt == LAST);

  always_ff @(posedge clk) begin
    if (!rst_b || clr)
      cnt <= '0;
    else if (en)
      cnt <= tc ? '0 : cnt + LW'(1);
  end

endmodule

// File: rtl/mem_access_ctrl.sv
// Sequencer between the core's load/store path and the cache/main memory:
// block refill on read miss, write-through on store, stall while busy.
module mem_access_ctrl
  import mem_ctrl_pkg::*;
#(
  parameter  int MEM_LATENCY = 4,
  parameter  int BLOCK_WORDS = 4,
  localparam int WI          = (BLOCK_WORDS > 1) ? $clog2(BLOCK_WORDS) : 1
) (
  input  logic          clk,
  input  logic          rst_b,
  input  logic          req_valid,
  input  logic          req_we,
  input  logic [31:0]   req_addr,
  input  logic          hit,
  input  logic          halted,
  output logic          stall,
  output logic [31:0]   mem_addr,
  output logic          mem_write_en,
  output logic          fill_we,
  output logic [WI-1:0] fill_word,
  output logic          fill_tag_we,
  output logic          cache_wr_hit
);

  localparam int            LW        = $clog2(MEM_LATENCY + 1);
  localparam int            BW_LOG2   = $clog2(BLOCK_WORDS);
  localparam logic [WI-1:0] LAST_WORD = WI'(BLOCK_WORDS - 1);

  mac_state_t    state, next;
  logic [31:0]   addr_q;
  logic          hit_q;
  logic [WI-1:0] word_cnt;
  logic [LW-1:0] lat_cnt;
  logic          lat_tc, lat_clr, lat_en;
  logic          accept, last_word;

  assign accept    = req_valid && !halted;
  assign last_word = (word_cnt == LAST_WORD);
  assign lat_clr   = (state == IDLE) || (state == DONE);
  assign lat_en    = (state == REFILL) || (state == WRITE);

  lat_counter #(.MEM_LATENCY(MEM_LATENCY)) u_lat (
    .clk  (clk),
    .rst_b(rst_b),
    .clr  (lat_clr),
    .en   (lat_en),
    .cnt  (lat_cnt),
    .tc   (lat_tc)
  );

  always_ff @(posedge clk) begin
    if (!rst_b) begin
      state    <= IDLE;
      addr_q   <= '0;
      hit_q    <= 1'b0;
      word_cnt <= '0;
    end else begin
      state <= next;
      if (state == IDLE && accept) begin
        addr_q   <= req_addr;
        hit_q    <= hit;
        word_cnt <= '0;
      end else if (state == REFILL && lat_tc) begin
        word_cnt <= last_word ? '0 : word_cnt + WI'(1);
      end
    end
  end

  always_comb begin
    next = state;
    case (state)
      IDLE:    if (accept) begin
                 if (req_we)   next = WRITE;
                 else if (!hit) next = REFILL;
               end
      REFILL:  if (lat_tc && last_word) next = DONE;
      WRITE:   if (lat_tc) next = DONE;
      DONE:    next = IDLE;
      default: next = IDLE;
    endcase
  end

  // In IDLE, stall is combinational so a load hit never loses a cycle.
  always_comb begin
    stall        = 1'b0;
    mem_addr     = '0;
    mem_write_en = 1'b0;
    fill_we      = 1'b0;
    fill_word    = '0;
    fill_tag_we  = 1'b0;
    cache_wr_hit = 1'b0;
    case (state)
      IDLE:   stall = accept && (req_we || !hit);
      REFILL: begin
        stall       = 1'b1;
        mem_addr    = line_base(addr_q, BW_LOG2) | (32'(word_cnt) << WORD_OFF);
        fill_we     = lat_tc;
        fill_word   = lat_tc ? word_cnt : '0;
        fill_tag_we = lat_tc && last_word;
      end
      WRITE: begin
        stall        = 1'b1;
        mem_addr     = {addr_q[31:2], 2'b00};
        mem_write_en = 1'b1;
        cache_wr_hit = hit_q && (lat_cnt == '0);
      end
      default: ;
    endcase
  end

endmodule

// File: tb/tb_mem_access_ctrl.sv
// Randomized bench for mem_access_ctrl: per-cycle expectations come from the
// transaction timeline (accept, BLOCK_WORDS*MEM_LATENCY refill or MEM_LATENCY write, done).
module tb_mem_access_ctrl;

  logic        clk = 1'b0;
  logic        rst_b;
  always #5 clk = ~clk;

  // default instance (MEM_LATENCY=4, BLOCK_WORDS=4)
  logic        rv_a, we_a, hit_a, hl_a;
  logic [31:0] ad_a;
  logic        stall_a, mwe_a, fwe_a, tag_a, wrh_a;
  logic [31:0] ma_a;
  logic [1:0]  fw_a;

  // minimal instance (MEM_LATENCY=1, BLOCK_WORDS=1)
  logic        rv_b, we_b, hit_b, hl_b;
  logic [31:0] ad_b;
  logic        stall_b, mwe_b, fwe_b, tag_b, wrh_b;
  logic [31:0] ma_b;
  logic [0:0]  fw_b;

  mem_access_ctrl u_dut_a (
    .clk(clk), .rst_b(rst_b), .req_valid(rv_a), .req_we(we_a), .req_addr(ad_a),
    .hit(hit_a), .halted(hl_a), .stall(stall_a), .mem_addr(ma_a),
    .mem_write_en(mwe_a), .fill_we(fwe_a), .fill_word(fw_a),
    .fill_tag_we(tag_a), .cache_wr_hit(wrh_a)
  );

  mem_access_ctrl #(.MEM_LATENCY(1), .BLOCK_WORDS(1)) u_dut_b (
    .clk(clk), .rst_b(rst_b), .req_valid(rv_b), .req_we(we_b), .req_addr(ad_b),
    .hit(hit_b), .halted(hl_b), .stall(stall_b), .mem_addr(ma_b),
    .mem_write_en(mwe_b), .fill_we(fwe_b), .fill_word(fw_b),
    .fill_tag_we(tag_b), .cache_wr_hit(wrh_b)
  );

  int n_chk  = 0;
  int n_pass = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_chk++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, obs, exp, $time);
  endtask

  task automatic drive(input int sel, input logic v, input logic w,
                       input logic [31:0] a, input logic h, input logic hl);
    if (sel == 0) begin rv_a = v; we_a = w; ad_a = a; hit_a = h; hl_a = hl; end
    else          begin rv_b = v; we_b = w; ad_b = a; hit_b = h; hl_b = hl; end
  endtask

  task automatic check_outs(input int sel, input string ph, input logic s,
                            input logic [31:0] ma, input logic mw, input logic fw,
                            input int fwd, input logic tw, input logic wh);
    if (sel == 0) begin
      chk($sformatf("%s.stall", ph),   32'(stall_a), 32'(s));
      chk($sformatf("%s.mem_addr", ph), ma_a, ma);
      chk($sformatf("%s.mem_we", ph),  32'(mwe_a), 32'(mw));
      chk($sformatf("%s.fill_we", ph), 32'(fwe_a), 32'(fw));
      chk($sformatf("%s.fill_word", ph), 32'(fw_a), 32'(fwd));
      chk($sformatf("%s.tag_we", ph),  32'(tag_a), 32'(tw));
      chk($sformatf("%s.wr_hit", ph),  32'(wrh_a), 32'(wh));
    end else begin
      chk($sformatf("%s.stall", ph),   32'(stall_b), 32'(s));
      chk($sformatf("%s.mem_addr", ph), ma_b, ma);
      chk($sformatf("%s.mem_we", ph),  32'(mwe_b), 32'(mw));
      chk($sformatf("%s.fill_we", ph), 32'(fwe_b), 32'(fw));
      chk($sformatf("%s.fill_word", ph), 32'(fw_b), 32'(fwd));
      chk($sformatf("%s.tag_we", ph),  32'(tag_b), 32'(tw));
      chk($sformatf("%s.wr_hit", ph),  32'(wrh_b), 32'(wh));
    end
  endtask

  // One transaction from its IDLE accept cycle through DONE. After cycle 0 the
  // request inputs carry junk (they must be ignored); halt_mid forces halted=1.
  // stop_after >= 0 abandons the transaction after that cycle index.
  task automatic run_txn(input int sel, input string ph, input int L, input int BW,
                         input logic v, input logic w, input logic [31:0] a,
                         input logic h, input logic hl, input bit halt_mid,
                         input int stop_after);
    int n;
    logic es, emw, efw, etw, ewh;
    logic [31:0] ema;
    int efwd;
    if (!v || hl || (!w && h)) n = 1;
    else if (!w)               n = 2 + BW * L;
    else                       n = 2 + L;
    for (int c = 0; c < n; c++) begin
      if (stop_after >= 0 && c > stop_after) break;
      @(negedge clk);
      if (c == 0) drive(sel, v, w, a, h, hl);
      else drive(sel, 1'($urandom), 1'($urandom), $urandom, 1'($urandom),
                 halt_mid ? 1'b1 : 1'($urandom));
      #1;
      es = 0; ema = 0; emw = 0; efw = 0; efwd = 0; etw = 0; ewh = 0;
      if (n > 1 && c < n - 1) es = 1;
      if (c >= 1 && c <= n - 2) begin
        if (!w) begin
          ema  = (a & ~(32'(BW * 4) - 32'd1)) + 32'(((c - 1) / L) * 4);
          efw  = (c % L) == 0;
          efwd = efw ? (c / L) - 1 : 0;
          etw  = (c == BW * L);
        end else begin
          ema = a & ~32'd3;
          emw = 1;
          ewh = h && (c == 1);
        end
      end
      check_outs(sel, ph, es, ema, emw, efw, efwd, etw, ewh);
    end
  endtask

  initial begin
    rst_b = 1'b0;
    drive(0, 0, 0, 0, 0, 0);
    drive(1, 0, 0, 0, 0, 0);
    repeat (3) @(posedge clk);
    @(negedge clk); #1;
    check_outs(0, "rst_a", 0, 0, 0, 0, 0, 0, 0);
    check_outs(1, "rst_b", 0, 0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_b = 1'b1;

    run_txn(0, "ld_hit",  4, 4, 1, 0, 32'h40,   1, 0, 0, -1);
    run_txn(0, "ld_miss", 4, 4, 1, 0, 32'h1234, 0, 0, 0, -1);
    run_txn(0, "st_hit",  4, 4, 1, 1, 32'h100,  1, 0, 0, -1);
    run_txn(0, "st_miss", 4, 4, 1, 1, 32'h100,  0, 0, 0, -1);

    // reset mid-refill right after fill_word 1 is written
    run_txn(0, "pre_rst", 4, 4, 1, 0, 32'h1234, 0, 0, 0, 8);
    @(negedge clk); rst_b = 1'b0; drive(0, 0, 0, 0, 0, 0);
    @(negedge clk); rst_b = 1'b1; #1;
    check_outs(0, "mid_rst", 0, 0, 0, 0, 0, 0, 0);
    // line stayed invalid: the same load misses again
    run_txn(0, "re_miss", 4, 4, 1, 0, 32'h1234, 0, 0, 0, -1);

    run_txn(0, "halt_pend", 4, 4, 1, 0, 32'h2000, 0, 1, 0, -1);
    run_txn(0, "halt_mid",  4, 4, 1, 0, 32'h2008, 0, 0, 1, -1);
    run_txn(0, "halt_pend2", 4, 4, 1, 1, 32'h2010, 1, 1, 0, -1);

    run_txn(1, "b_miss", 1, 1, 1, 0, 32'h0000_abcd, 0, 0, 0, -1);
    run_txn(1, "b_st",   1, 1, 1, 1, 32'h0000_5557, 1, 0, 0, -1);
    run_txn(1, "b_hit",  1, 1, 1, 0, 32'h0000_0010, 1, 0, 0, -1);

    for (int i = 0; i < 40; i++)
      run_txn(0, "rnd", 4, 4, 1'($urandom_range(0, 3) != 0), 1'($urandom),
              $urandom, 1'($urandom), 1'($urandom_range(0, 7) == 0), 0, -1);
    for (int i = 0; i < 20; i++)
      run_txn(1, "rnd_b", 1, 1, 1'($urandom_range(0, 3) != 0), 1'($urandom),
              $urandom, 1'($urandom), 1'($urandom_range(0, 7) == 0), 0, -1);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
